// File: rtl/multicycle_controlunit.sv
// multicycle_controlunit
//
// Control unit for the multicycle UWARM processor (Harris & Harris ARM
// datapath). A Moore state machine sequences one shared memory port and one
// ALU through fetch, decode, address generation, execute, write-back and
// branch-target computation. It also keeps the stored NZCV flags used for
// conditional execution.
//
// Parameters
//   ALUCTRL_W     width of ALUControl (>= 3, upper bits driven 0)
//   MEM_HANDSHAKE 1: MemReady honoured, 0: MemReady treated as always 1
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Instr[31:0]       instruction register contents
//   Flags[3:0]        ALU {N,Z,C,V} of the current cycle
//   MemReady          memory completes the access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite   datapath strobes
//   ResultSrc, ALUSrcB, ImmSrc, RegSrc                      datapath selects
//   ALUControl        ALU operation code
//   State[3:0]        current state encoding (debug)
module multicycle_controlunit #(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           Flags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Full ARM condition table; 1111 behaves as AL.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // ALU opcode for a data-processing cmd; unsupported cmds map to ADD.
  function automatic logic [2:0] cmd_alu_code(input logic [3:0] cmd);
    logic [2:0] code;
    case (cmd)
      4'b0100: code = 3'd0;
      4'b0010: code = 3'd1;
      4'b0000: code = 3'd2;
      4'b1100: code = 3'd3;
      4'b0001: code = 3'd4;
      4'b1101: code = 3'd5;
      4'b1010: code = 3'd1;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // True for every cmd the datapath implements (CMP included).
  function automatic logic cmd_supported(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      4'b0100, 4'b0010, 4'b0000, 4'b1100,
      4'b0001, 4'b1101, 4'b1010: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Arithmetic cmds update all of NZCV; logical ones only N and Z.
  function automatic logic cmd_full_flags(input logic [3:0] cmd);
    logic full;
    case (cmd)
      4'b0100, 4'b0010, 4'b1010: full = 1'b1;
      default:                   full = 1'b0;
    endcase
    return full;
  endfunction

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  nzcv_r;

  logic [3:0]  cond_s;
  logic [1:0]  op_s;
  logic [5:0]  funct_s;
  logic [3:0]  rd_s;
  logic [3:0]  cmd_s;
  logic        s_bit_s;
  logic        cond_ex_s;
  logic        mem_ready_s;
  logic        is_cmp_s;
  logic        cmd_ok_s;
  logic        in_exec_s;
  logic        flag_wr_s;
  logic [2:0]  alu_code_s;
  logic        unused_instr_s;

  assign cond_s    = Instr[31:28];
  assign op_s      = Instr[27:26];
  assign funct_s   = Instr[25:20];
  assign rd_s      = Instr[15:12];
  assign cmd_s     = funct_s[4:1];
  assign s_bit_s   = funct_s[0];

  // Register fields and the immediate are consumed by the datapath, not here.
  assign unused_instr_s = ^{Instr[19:16], Instr[11:0]};

  assign mem_ready_s = MEM_HANDSHAKE ? MemReady : 1'b1;
  assign cond_ex_s   = cond_holds(cond_s, nzcv_r);
  assign is_cmp_s    = (cmd_s == 4'b1010);
  assign cmd_ok_s    = cmd_supported(cmd_s);
  assign alu_code_s  = cmd_alu_code(cmd_s);
  assign in_exec_s   = (state_r == S_EXECUTER) || (state_r == S_EXECUTEI);
  // Execute lasts one cycle, so every edge seen in it is the leaving edge.
  assign flag_wr_s   = in_exec_s && ((s_bit_s && cmd_ok_s) || is_cmp_s);

  assign ImmSrc = op_s;
  assign RegSrc = {(op_s == 2'b01) && !funct_s[0], (op_s == 2'b10)};
  assign State  = state_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Stored NZCV; logical ops keep C and V.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_r <= 4'b0000;
    end else if (flag_wr_s) begin
      if (cmd_full_flags(cmd_s)) begin
        nzcv_r <= Flags;
      end else begin
        nzcv_r <= {Flags[3:2], nzcv_r[1:0]};
      end
    end else begin
      nzcv_r <= nzcv_r;
    end
  end

  // Next-state and Moore outputs (IRWrite/PCWrite in FETCH follow MemReady).
  always_comb begin
    state_nx_s = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
    case (state_r)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready_s;
        PCWrite   = mem_ready_s;
        if (mem_ready_s) begin
          state_nx_s = S_DECODE;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ex_s) begin
          state_nx_s = S_FETCH;
        end else begin
          case (op_s)
            2'b01: state_nx_s = S_MEMADR;
            2'b00: begin
              if (funct_s[5]) begin
                state_nx_s = S_EXECUTEI;
              end else begin
                state_nx_s = S_EXECUTER;
              end
            end
            2'b10:   state_nx_s = S_BRANCH;
            default: state_nx_s = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        if (funct_s[0]) begin
          state_nx_s = S_MEMREAD;
        end else begin
          state_nx_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready_s) begin
          state_nx_s = S_MEMWB;
        end else begin
          state_nx_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_nx_s = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready_s) begin
          state_nx_s = S_FETCH;
        end else begin
          state_nx_s = S_MEMWRITE;
        end
      end
      S_EXECUTER, S_EXECUTEI: begin
        if (state_r == S_EXECUTEI) begin
          ALUSrcB = 2'b01;
        end else begin
          ALUSrcB = 2'b00;
        end
        ALUControl[2:0] = alu_code_s;
        // CMP and unsupported cmds produce no register result.
        if (is_cmp_s || !cmd_ok_s) begin
          state_nx_s = S_FETCH;
        end else begin
          state_nx_s = S_ALUWB;
        end
      end
      S_ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        PCWrite    = (rd_s == 4'd15);
        state_nx_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_nx_s = S_FETCH;
      end
      default: begin
        state_nx_s = S_FETCH;
      end
    endcase
  end

endmodule

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Parametrised control unit for the multicycle UWARM processor, following the Harris & Harris ARM datapath. It replaces single-cycle decoding with a Moore-style state machine, so one shared memory port and one ALU serve fetch, address, execute and branch-target computation. It adds a memory-ready handshake, conditional-instruction annulment, EOR/MOV decode and a debug state port. It sits between the instruction register/status logic and the multicycle datapath muxes.

## Interface
- ALUCTRL_W, 3, width of ALUControl; must be ≥3; upper bits are driven 0.
- MEM_HANDSHAKE, 1, 1: MemReady is honoured; 0: MemReady is treated as constant 1.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces FETCH and clears NZCV
- Instr  in  32  current IR contents, stable from DECODE until the next FETCH completes
- Flags  in  4  ALU {N,Z,C,V} of the current cycle
- MemReady  in  1  memory completes the access this cycle
- PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite  out  1  datapath strobes/selects
- ResultSrc, ALUSrcB, ImmSrc, RegSrc  out  2  datapath selects; ImmSrc = Instr[27:26]; RegSrc = {Op==01 & !Funct[0], Op==10}
- ALUControl  out  ALUCTRL_W  ALU operation code
- State  out  4  current state encoding (debug)

## Operation
- **Fields:** Cond = [31:28], Op = [27:26], Funct = [25:20], Rd = [15:12], cmd = Funct[4:1], S = Funct[0].
- **Stored NZCV:** CondEx is evaluated combinationally from Cond and NZCV using the full ARM condition table; 1111 is treated as AL.
- **Default outputs:** all 0, ALUControl = 0 (ADD).
- **FETCH (0):**
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady, then goes to DECODE.
- **DECODE (1):**
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - If !CondEx → FETCH (annulled instruction).
  - Otherwise: Op=01 → MEMADR; Op=00 & !Funct[5] → EXECUTER; Op=00 & Funct[5] → EXECUTEI; Op=10 → BRANCH; Op=11 → FETCH.
- **MEMADR (2):** ALUSrcB=01, ADD. Funct[0]=1 → MEMREAD; otherwise → MEMWRITE.
- **MEMREAD (3):** AdrSrc=1. Holds until MemReady, then → MEMWB.
- **MEMWB (4):** ResultSrc=01, RegWrite=1 → FETCH.
- **MEMWRITE (5):** AdrSrc=1, MemWrite=1, held until MemReady, then → FETCH.
- **EXECUTER (6) / EXECUTEI (7):**
  - ALUSrcB=00 / 01; ALUControl comes from the cmd decode.
  - CMP or unsupported cmd → FETCH; otherwise → ALUWB.
- **ALUWB (8):** ResultSrc=00, RegWrite=1; PCWrite=1 when Rd==15. → FETCH.
- **BRANCH (9):** ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1 → FETCH.
- **Encodings 10–15:** illegal; they go to FETCH with default outputs.
- **cmd decode (code, flag group):**
  - ADD 0100→0, NZCV
  - SUB 0010→1, NZCV
  - AND 0000→2, NZ
  - ORR 1100→3, NZ
  - EOR 0001→4, NZ
  - MOV 1101→5, NZ
  - CMP 1010→1, NZCV always
  - Any other cmd: ALUControl 0, no flag or register write.
- **Flag update:** the flag group is written from Flags on the clock edge leaving EXECUTER/EXECUTEI, only when S=1 or cmd is CMP.

## Timing
- **Reset:** asynchronous. State=FETCH, NZCV=0000. Every output reverts to its FETCH value immediately: MemWrite=0, RegWrite=0, IRWrite=PCWrite=MemReady. Reset mid-access abandons the instruction with no further writes.
- **Output types:** Moore outputs except IRWrite/PCWrite in FETCH, which depend on MemReady.
- **Cycles with zero wait:**
  - annulled: 2
  - B: 3
  - CMP / unsupported: 3
  - data-processing: 4
  - STR: 4
  - LDR: 5
- **Wait states:** each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly 1 cycle. Outputs are held constant while waiting.
- **Flag visibility:** flags written by instruction N are visible to CondEx of instruction N+1 in its DECODE.

## Test plan
- **Reset:** assert reset mid-MEMWRITE with MemReady=0 → MemWrite drops the same cycle; State=0; NZCV=0 after release; first fetch proceeds.
- **ADD, no wait:** Instr=E0821003, MemReady=1 → State sequence 0,1,6,8,0; RegWrite only in state 8; flags unchanged.
- **SUBS then EQ:** Instr=E2500001 with Flags=0100 in EXECUTEI → Z=1 stored. Then ADDEQ 00821003 executes; with Z=0 the same ADDEQ annuls (0,1,0, no RegWrite).
- **LDR with waits:** Instr=E5921004, MemReady low 2 cycles in FETCH and 3 in MEMREAD → 10 total cycles; AdrSrc=1 held in MEMREAD; RegWrite with ResultSrc=01 once.
- **STR and branch:** STR E5821004 → MemWrite held through waits, then state 0. B EA000002 → states 0,1,9 with PCWrite=1 in BRANCH.
- **CMP / MOV to PC:** CMP E1510002 → 3 cycles, NZCV loaded, no RegWrite. MOV PC,R1 E1A0F001 → ALUControl=5; in ALUWB RegWrite=1 and PCWrite=1.
